// File: rtl/mem_pkg.sv
// Shared types and helpers for the line-granular main-memory controller.
package mem_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, BURST, RESP} mem_state_t;

    typedef logic [31:0] word_t;

    // Latency counter must hold LATENCY itself; keep at least one bit for LATENCY == 0.
    function automatic int unsigned cnt_width(input int unsigned latency);
        return (latency == 0) ? 1 : $clog2(latency + 1);
    endfunction

endpackage

// File: rtl/line_mem_ram.sv
// Single-port synchronous word RAM, one-cycle read latency.
// Powers up reading back each word's own address.
module line_mem_ram
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 13
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  word_t             wdata,
    output word_t             rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    word_t mem [DEPTH];

    // Storage keeps data XOR address, so all-zero power-up content reads as w at address w.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata ^ word_t'(addr);
        end
        rdata <= mem[addr] ^ word_t'(addr);
    end

endmodule

// File: rtl/line_mem_ctrl.sv
// Line-granular memory controller: latency wait, then one word per cycle burst to/from the RAM,
// completion signalled with a single-cycle gnt.
module line_mem_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned LINE_ADDR_LEN = 3,
    parameter int unsigned ADDR_LEN      = 10,
    parameter int unsigned LATENCY       = 16
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic  [ADDR_LEN-1:0]                 addr,
    input  logic                                 rd_req,
    input  logic                                 wr_req,
    input  word_t [(1 << LINE_ADDR_LEN)-1:0]     wr_line,
    output word_t [(1 << LINE_ADDR_LEN)-1:0]     rd_line,
    output logic                                 gnt
);

    localparam int unsigned LINE_SIZE = 1 << LINE_ADDR_LEN;
    localparam int unsigned CNT_W     = cnt_width(LATENCY);
    localparam int unsigned RAM_AW    = ADDR_LEN + LINE_ADDR_LEN;
    localparam logic [LINE_ADDR_LEN-1:0] LAST_IDX = LINE_ADDR_LEN'(LINE_SIZE - 1);
    localparam logic [CNT_W-1:0]         CNT_LOAD = CNT_W'(LATENCY);

    mem_state_t                   state_q, state_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [LINE_ADDR_LEN-1:0]     idx_q, idx_d;
    logic [ADDR_LEN-1:0]          addr_q, addr_d;
    logic                         is_wr_q, is_wr_d;
    word_t [LINE_SIZE-1:0]        wr_buf_q, wr_buf_d;
    word_t [LINE_SIZE-1:0]        rd_line_q;
    logic                         rd_pend_q;
    logic [LINE_ADDR_LEN-1:0]     rd_idx_q;
    logic                         ram_we;
    logic [RAM_AW-1:0]            ram_addr;
    word_t                        ram_wdata;
    word_t                        ram_rdata;

    assign ram_addr  = {addr_q, idx_q};
    assign ram_wdata = wr_buf_q[idx_q];
    assign rd_line   = rd_line_q;

    line_mem_ram #(
        .ADDR_W (RAM_AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        addr_d   = addr_q;
        is_wr_d  = is_wr_q;
        wr_buf_d = wr_buf_q;
        ram_we   = 1'b0;
        gnt      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (wr_req || rd_req) begin
                    addr_d   = addr;
                    is_wr_d  = wr_req;
                    wr_buf_d = wr_line;
                    cnt_d    = CNT_LOAD;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    idx_d   = '0;
                    state_d = BURST;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            BURST: begin
                ram_we = is_wr_q;
                idx_d  = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                gnt     = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            addr_q    <= '0;
            is_wr_q   <= 1'b0;
            wr_buf_q  <= '0;
            rd_line_q <= '0;
            rd_pend_q <= 1'b0;
            rd_idx_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            addr_q    <= addr_d;
            is_wr_q   <= is_wr_d;
            wr_buf_q  <= wr_buf_d;
            // Read data trails the RAM access by one cycle; the last word lands during RESP.
            rd_pend_q <= (state_q == BURST) && !is_wr_q;
            rd_idx_q  <= idx_q;
            if (rd_pend_q) begin
                rd_line_q[rd_idx_q] <= ram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_line_mem_ctrl.sv
// Scoreboard bench: two controller builds (LATENCY 4 and 0) driven with directed line requests.
module tb_line_mem_ctrl;
    import mem_pkg::*;

    localparam int LS = 8;

    typedef word_t [LS-1:0] line_t;

    typedef struct {
        longint cyc;
        line_t  line;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n   [2];
    logic [9:0]  addr    [2];
    logic        rd_req  [2];
    logic        wr_req  [2];
    line_t       wr_line [2];
    line_t       rd_line [2];
    logic        gnt     [2];

    longint      cyc = 0;
    int          n_vec = 0;
    int          n_miss = 0;
    exp_t        sb0[$];
    exp_t        sb1[$];
    word_t       wmem0[int];
    word_t       wmem1[int];
    line_t       last_rd [2];

    line_mem_ctrl #(
        .LINE_ADDR_LEN (3),
        .ADDR_LEN      (10),
        .LATENCY       (4)
    ) dut4 (
        .clk     (clk),
        .rst_n   (rst_n[0]),
        .addr    (addr[0]),
        .rd_req  (rd_req[0]),
        .wr_req  (wr_req[0]),
        .wr_line (wr_line[0]),
        .rd_line (rd_line[0]),
        .gnt     (gnt[0])
    );

    line_mem_ctrl #(
        .LINE_ADDR_LEN (3),
        .ADDR_LEN      (10),
        .LATENCY       (0)
    ) dut0 (
        .clk     (clk),
        .rst_n   (rst_n[1]),
        .addr    (addr[1]),
        .rd_req  (rd_req[1]),
        .wr_req  (wr_req[1]),
        .wr_line (wr_line[1]),
        .rd_line (rd_line[1]),
        .gnt     (gnt[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic word_t model_word(input int id, input int w);
        if (id == 0) return wmem0.exists(w) ? wmem0[w] : word_t'(w);
        return wmem1.exists(w) ? wmem1[w] : word_t'(w);
    endfunction

    function automatic line_t model_line(input int id, input logic [9:0] a);
        line_t l;
        for (int k = 0; k < LS; k++) l[k] = model_word(id, int'(a) * LS + k);
        return l;
    endfunction

    function automatic line_t mk_line(input word_t base);
        line_t l;
        for (int k = 0; k < LS; k++) l[k] = base + word_t'(k);
        return l;
    endfunction

    // Called at posedge+#1 of the issuing IDLE cycle; returns at posedge+#1 of the cycle after gnt.
    task automatic request(input int id, input bit wr, input bit rd, input logic [9:0] a,
                           input line_t l, input int lat);
        exp_t e;
        bit   seen;
        addr[id]    = a;
        wr_req[id]  = wr;
        rd_req[id]  = rd;
        wr_line[id] = l;
        e.cyc = cyc + lat + LS + 2;
        if (wr) begin
            for (int k = 0; k < LS; k++) begin
                if (id == 0) wmem0[int'(a) * LS + k] = l[k];
                else         wmem1[int'(a) * LS + k] = l[k];
            end
            e.line = last_rd[id];
        end else begin
            e.line      = model_line(id, a);
            last_rd[id] = e.line;
        end
        if (id == 0) sb0.push_back(e);
        else         sb1.push_back(e);
        seen = 1'b0;
        for (int i = 0; i < 80 && !seen; i++) begin
            @(negedge clk);
            seen = (gnt[id] === 1'b1);
        end
        if (!seen) check("gnt_timeout", 256'(0), 256'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int id);
        rd_req[id] = 1'b0;
        wr_req[id] = 1'b0;
    endtask

    task automatic mon(input int id);
        forever begin
            @(negedge clk);
            if (gnt[id] === 1'b1) begin
                exp_t e;
                bit   have;
                have = (id == 0) ? (sb0.size() != 0) : (sb1.size() != 0);
                if (!have) begin
                    check("unexpected_gnt", 256'(1), 256'(0));
                end else begin
                    e = (id == 0) ? sb0.pop_front() : sb1.pop_front();
                    check("gnt_cycle", 256'(cyc), 256'(e.cyc));
                    @(negedge clk);
                    check("gnt_pulse", 256'(gnt[id]), 256'(0));
                    check("rd_line", 256'(rd_line[id]), 256'(e.line));
                end
            end
        end
    endtask

    initial begin
        fork
            mon(0);
            mon(1);
        join_none
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst_n[i]   = 1'b0;
            addr[i]    = '0;
            rd_req[i]  = 1'b0;
            wr_req[i]  = 1'b0;
            wr_line[i] = '0;
            last_rd[i] = '0;
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            check("reset_gnt", 256'(gnt[i]), 256'(0));
            check("reset_rd_line", 256'(rd_line[i]), 256'(0));
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        @(posedge clk);
        #1;

        // T1: plain read, gnt at t+14
        request(0, 1'b0, 1'b1, 10'h005, '0, 4);
        idle(0);
        // T2: write, readback, neighbour untouched
        request(0, 1'b1, 1'b0, 10'h005, mk_line(32'hA0), 4);
        idle(0);
        request(0, 1'b0, 1'b1, 10'h005, '0, 4);
        request(0, 1'b0, 1'b1, 10'h006, '0, 4);
        idle(0);
        // T3: swap-out then swap-in switched at the gnt edge
        request(0, 1'b1, 1'b0, 10'h010, mk_line(32'hB0), 4);
        request(0, 1'b0, 1'b1, 10'h020, '0, 4);
        idle(0);
        // T4: both requests high, write wins, read follows
        request(0, 1'b1, 1'b1, 10'h003, mk_line(32'hC0), 4);
        request(0, 1'b0, 1'b1, 10'h003, '0, 4);
        idle(0);

        // T5: reset mid-burst, then a fresh read
        addr[0]   = 10'h040;
        rd_req[0] = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        rst_n[0]  = 1'b0;
        rd_req[0] = 1'b0;
        #1;
        check("midreset_gnt", 256'(gnt[0]), 256'(0));
        check("midreset_rd_line", 256'(rd_line[0]), 256'(0));
        last_rd[0] = '0;
        @(posedge clk);
        #1;
        rst_n[0] = 1'b1;
        @(posedge clk);
        #1;
        request(0, 1'b0, 1'b1, 10'h005, '0, 4);
        idle(0);

        // T6: zero-latency build at the top of the address space
        request(1, 1'b0, 1'b1, 10'h3FF, '0, 0);
        request(1, 1'b1, 1'b0, 10'h3FF, mk_line(32'hD0), 0);
        request(1, 1'b0, 1'b1, 10'h000, '0, 0);
        request(1, 1'b0, 1'b1, 10'h3FF, '0, 0);
        idle(1);

        repeat (4) @(negedge clk);
        check("scoreboard_drain", 256'(sb0.size() + sb1.size()), 256'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
